// File: rtl/aes_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_pkg : AES state widths, inverse S-box table and engine FSM encoding
// Rev 1.0
// ----------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_NBYTES  = 16;

  // Byte 0 sits at the MSB end, matching the [0:127] state bus ordering.
  typedef logic [0:AES_NBYTES-1][7:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_fsm_e;

  // Entry 0 is the leftmost byte of the concatenation.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_sbox.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_inv_sbox : combinational AES inverse S-box, one byte
// Rev 1.0
// ----------------------------------------------------------------------------
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = inv_sbox(i_byte);

endmodule
`default_nettype wire

// File: rtl/inv_sub_bytes_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// inv_sub_bytes_iter : iterative AES InvSubBytes, BYTES_PER_CYCLE bytes/clock
// Rev 1.0
// ----------------------------------------------------------------------------
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:AES_STATE_W-1] in_vector,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:AES_STATE_W-1] out_vector,
  output logic                   busy
);

  localparam logic [4:0] c_step = 5'(BYTES_PER_CYCLE);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bytes_per_cycle
    $fatal(1, "inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  aes_fsm_e   state_q, state_d;
  logic [3:0] idx_q, idx_d;
  aes_state_t work_q, work_d;
  logic [7:0] w_sbox_out [BYTES_PER_CYCLE];
  logic       w_last_chunk;

  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
    logic [3:0] w_lane_idx;
    assign w_lane_idx = idx_q + 4'(j);

    aes_inv_sbox u_inv_sbox (
      .i_byte (work_q[w_lane_idx]),
      .o_byte (w_sbox_out[j])
    );
  end

  // Widened compare: with 16 lanes the 4-bit index never moves, so wrap cannot be used.
  assign w_last_chunk = (({1'b0, idx_q} + c_step) == 5'd16);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    work_d  = work_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = in_vector;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
          work_d[idx_q + 4'(j)] = w_sbox_out[j];
        end
        idx_d = idx_q + c_step[3:0];
        if (w_last_chunk) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  // Gated so a partially substituted state never appears on the bus.
  assign out_vector = out_valid ? work_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_inv_sub_bytes_iter : self-checking bench, all legal BYTES_PER_CYCLE values
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_inv_sub_bytes_iter;

  localparam int NINST = 5;
  localparam int BPC_LIST [NINST] = '{4, 1, 2, 8, 16};

  logic         clk = 1'b0;
  logic         rst_n;
  logic [0:127] in_vector;
  logic         in_valid   [NINST];
  logic         in_ready   [NINST];
  logic         out_valid  [NINST];
  logic         out_ready  [NINST];
  logic [0:127] out_vector [NINST];
  logic         busy       [NINST];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(BPC_LIST[g])) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_vector  (in_vector),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_vector (out_vector[g]),
      .busy       (busy[g])
    );
  end

  int           n_checks = 0;
  int           n_pass   = 0;
  longint       cyc      = 0;
  logic [0:127] sb [$];
  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [0:127] act, input logic [0:127] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %032h expected %032h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Forward S-box derived from GF(2^8) inversion plus the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in, b = b_in, p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [0:127] sub_bytes(input logic [0:127] v);
    logic [0:127] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = fwd_tab[v[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [0:127] inv_model(input logic [0:127] v);
    logic [0:127] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tab[v[8*k +: 8]];
    return r;
  endfunction

  // Scoreboard consumer for instance 0: every output handshake pops one expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid[0] && out_ready[0]) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got output %032h expected none", out_vector[0]);
      end else begin
        check("sb_result", out_vector[0], sb.pop_front());
      end
    end
  end

  task automatic send(input int k, input logic [0:127] v, input logic [0:127] e,
                      output longint t_acc);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_vector   = v;
    in_valid[k] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready[k]) begin ok = 1'b1; break; end
    end
    if (!ok) fail("send_accept");
    else if (k == 0) sb.push_back(e);
    @(posedge clk); #1;
    t_acc       = cyc;
    in_valid[k] = 1'b0;
    in_vector   = 'x;
  endtask

  task automatic wait_valid(input int k, input longint t_acc, output longint lat);
    bit ok = 1'b0;
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid[k]) begin ok = 1'b1; break; end
    end
    if (!ok) fail($sformatf("out_valid_inst%0d", k));
    else lat = cyc - t_acc;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) fail("sb_drain");
  endtask

  typedef struct {
    logic [0:127] vin;
    logic [0:127] vexp;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl [5];
    longint       t_acc, lat;
    logic [0:127] v, hold;
    longint       acc_t [2];
    int           n_acc;

    tbl[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
    tbl[1] = '{{16{8'h63}}, {16{8'h00}}};
    tbl[2] = '{{16{8'h00}}, {16{8'h52}}};
    tbl[3] = '{{16{8'h16}}, {16{8'hff}}};
    tbl[4] = '{{16{8'h7c}}, {16{8'h01}}};

    build_tables();
    in_vector = '0;
    for (int k = 0; k < NINST; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",   128'(in_ready[0]),  128'd1);
    check("rst_out_valid",  128'(out_valid[0]), 128'd0);
    check("rst_busy",       128'(busy[0]),      128'd0);
    check("rst_out_vector", out_vector[0],      128'd0);
    rst_n = 1'b1;

    // Table vectors; the first also pins the 4-cycle latency.
    for (int i = 0; i < 5; i++) begin
      send(0, tbl[i].vin, tbl[i].vexp, t_acc);
      wait_valid(0, t_acc, lat);
      if (i == 0) check("t1_latency", 128'(lat), 128'd4);
      drain();
    end

    // Backpressure: result and flags held for 10 cycles.
    @(posedge clk); #1; out_ready[0] = 1'b0;
    v = 128'h0123456789abcdeffedcba9876543210;
    send(0, v, inv_model(v), t_acc);
    wait_valid(0, t_acc, lat);
    hold = out_vector[0];
    check("bp_first_value", hold, inv_model(v));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid",  128'(out_valid[0]), 128'd1);
      check("bp_out_vector", out_vector[0], hold);
      check("bp_in_ready",   128'(in_ready[0]), 128'd0);
    end
    @(posedge clk); #1; out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready",  128'(in_ready[0]),  128'd1);
    check("bp_release_out_valid", 128'(out_valid[0]), 128'd0);
    drain();

    // Input offered during RUN must be ignored.
    v = 128'h00112233445566778899aabbccddeeff;
    send(0, v, inv_model(v), t_acc);
    in_vector = 128'hdeadbeefcafef00d0badc0de12345678;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    in_vector = 'x;
    drain();
    repeat (10) @(negedge clk);
    check("busy_idle_after", 128'(busy[0]), 128'd0);

    // Back-to-back with out_ready tied high: one state per NCYC+2 cycles.
    @(posedge clk); #1;
    in_vector   = 128'h3243f6a8885a308d313198a2e0370734;
    in_valid[0] = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 100 && n_acc < 2; i++) begin
      @(negedge clk);
      if (in_ready[0]) begin
        sb.push_back(inv_model(in_vector));
        @(posedge clk); #1;
        acc_t[n_acc] = cyc;
        n_acc++;
        in_vector = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        if (n_acc == 2) begin
          in_valid[0] = 1'b0;
          in_vector   = 'x;
        end
      end
    end
    if (n_acc < 2) begin
      fail("b2b_accept");
      in_valid[0] = 1'b0;
    end else begin
      check("b2b_period", 128'(acc_t[1] - acc_t[0]), 128'd6);
      wait_valid(0, acc_t[0], lat);
      check("b2b_second_done", 128'(lat), 128'd10);
    end
    drain();

    // Reset abort two cycles into RUN.
    v = 128'hffeeddccbbaa99887766554433221100;
    send(0, v, inv_model(v), t_acc);
    @(posedge clk); @(posedge clk); #2;
    check("abort_run_out_vector", out_vector[0], 128'd0);
    check("abort_run_busy", 128'(busy[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid",  128'(out_valid[0]), 128'd0);
    check("abort_out_vector", out_vector[0],       128'd0);
    check("abort_in_ready",   128'(in_ready[0]),   128'd1);
    check("abort_busy",       128'(busy[0]),       128'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    v = 128'h6bc1bee22e409f96e93d7e117393172a;
    send(0, v, inv_model(v), t_acc);
    drain();

    // Latency and result for the other lane counts.
    for (int k = 1; k < NINST; k++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      send(k, v, inv_model(v), t_acc);
      wait_valid(k, t_acc, lat);
      check($sformatf("lat_bpc%0d", BPC_LIST[k]), 128'(lat), 128'(16 / BPC_LIST[k]));
      check($sformatf("result_bpc%0d", BPC_LIST[k]), out_vector[k], inv_model(v));
    end

    // Round trip through the forward SubBytes model.
    for (int n = 0; n < 1000; n++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      send(0, sub_bytes(v), v, t_acc);
    end
    drain();
    check("sb_empty_at_end", 128'(sb.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
